// File: rtl/line_fifo.sv
// Multi-line scanline buffer: LINE_NUM register slots, each line replayed RD_TIMES times.
// Define LINE_FIFO_CNT_EN to expose the committed-line count on lvl_o.
module line_fifo #(
  parameter  int SIZE      = 256,
  parameter  int DATA_WD   = 8,
  parameter  int LINE_NUM  = 2,
  parameter  int RD_TIMES  = 3,
  localparam int SIZE_WD   = (SIZE > 1) ? $clog2(SIZE) : 1,
  localparam int SIZE_W_WD = $clog2(SIZE + 1),
  localparam int LIN_WD    = (LINE_NUM > 1) ? $clog2(LINE_NUM) : 1,
  localparam int PAS_WD    = (RD_TIMES > 1) ? $clog2(RD_TIMES) : 1,
  localparam int CNT_WD    = $clog2(LINE_NUM + 1)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [SIZE_W_WD-1:0] cfg_w_i,
  input  logic                 start_i,
  input  logic                 wr_val_i,
  input  logic [DATA_WD-1:0]   wr_dat_i,
  output logic                 wr_rdy_o,
  input  logic                 rd_val_i,
  output logic                 rd_rdy_o,
  output logic                 rd_val_o,
  output logic [DATA_WD-1:0]   rd_dat_o,
  output logic [PAS_WD-1:0]    rd_pas_o,
  output logic                 rd_lst_o
`ifdef LINE_FIFO_CNT_EN
  ,
  output logic [CNT_WD-1:0]    lvl_o
`endif
);

  logic [DATA_WD-1:0] mem_q [LINE_NUM][SIZE];

  logic [LIN_WD-1:0]  wr_lin_q, wr_lin_d, rd_lin_q, rd_lin_d;
  logic [SIZE_WD-1:0] wr_col_q, wr_col_d, rd_col_q, rd_col_d;
  logic [PAS_WD-1:0]  rd_pas_q, rd_pas_d;
  logic [CNT_WD-1:0]  lin_cnt_q, lin_cnt_d;
  logic               out_val_q, out_val_d, out_lst_q, out_lst_d;
  logic [DATA_WD-1:0] out_dat_q, out_dat_d;
  logic [PAS_WD-1:0]  out_pas_q, out_pas_d;

  logic [SIZE_W_WD-1:0] col_last;
  logic wr_acc, rd_acc, wr_col_end, rd_col_end, rd_pas_end, commit, release_l;

  // Handshake: a request is accepted in the cycle where valid and ready are both high;
  // start_i masks both so a frame restart never stores or fetches a word.
  assign wr_rdy_o   = (lin_cnt_q != CNT_WD'(LINE_NUM));
  assign rd_rdy_o   = (lin_cnt_q != '0);
  assign wr_acc     = wr_val_i & wr_rdy_o & ~start_i;
  assign rd_acc     = rd_val_i & rd_rdy_o & ~start_i;
  assign col_last   = cfg_w_i - 1'b1;
  assign wr_col_end = (SIZE_W_WD'(wr_col_q) == col_last);
  assign rd_col_end = (SIZE_W_WD'(rd_col_q) == col_last);
  assign rd_pas_end = (rd_pas_q == PAS_WD'(RD_TIMES - 1));
  assign commit     = wr_acc & wr_col_end;
  assign release_l  = rd_acc & rd_col_end & rd_pas_end;

  always_comb begin
    wr_lin_d  = wr_lin_q;
    wr_col_d  = wr_col_q;
    rd_lin_d  = rd_lin_q;
    rd_col_d  = rd_col_q;
    rd_pas_d  = rd_pas_q;
    lin_cnt_d = lin_cnt_q;
    out_val_d = 1'b0;
    out_dat_d = out_dat_q;
    out_pas_d = out_pas_q;
    out_lst_d = out_lst_q;
    if (start_i) begin
      wr_lin_d  = '0;
      wr_col_d  = '0;
      rd_lin_d  = '0;
      rd_col_d  = '0;
      rd_pas_d  = '0;
      lin_cnt_d = '0;
    end else begin
      if (wr_acc) begin
        if (wr_col_end) begin
          wr_col_d = '0;
          wr_lin_d = (wr_lin_q == LIN_WD'(LINE_NUM - 1)) ? '0 : wr_lin_q + 1'b1;
        end else begin
          wr_col_d = wr_col_q + 1'b1;
        end
      end
      if (rd_acc) begin
        out_val_d = 1'b1;
        out_dat_d = mem_q[rd_lin_q][rd_col_q];
        out_pas_d = rd_pas_q;
        out_lst_d = rd_col_end & rd_pas_end;
        if (rd_col_end) begin
          rd_col_d = '0;
          if (rd_pas_end) begin
            rd_pas_d = '0;
            rd_lin_d = (rd_lin_q == LIN_WD'(LINE_NUM - 1)) ? '0 : rd_lin_q + 1'b1;
          end else begin
            rd_pas_d = rd_pas_q + 1'b1;
          end
        end else begin
          rd_col_d = rd_col_q + 1'b1;
        end
      end
      // A commit and a release in the same cycle cancel out.
      case ({commit, release_l})
        2'b10:   lin_cnt_d = lin_cnt_q + 1'b1;
        2'b01:   lin_cnt_d = lin_cnt_q - 1'b1;
        default: lin_cnt_d = lin_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_lin_q  <= '0;
      wr_col_q  <= '0;
      rd_lin_q  <= '0;
      rd_col_q  <= '0;
      rd_pas_q  <= '0;
      lin_cnt_q <= '0;
      out_val_q <= 1'b0;
      out_dat_q <= '0;
      out_pas_q <= '0;
      out_lst_q <= 1'b0;
    end else begin
      wr_lin_q  <= wr_lin_d;
      wr_col_q  <= wr_col_d;
      rd_lin_q  <= rd_lin_d;
      rd_col_q  <= rd_col_d;
      rd_pas_q  <= rd_pas_d;
      lin_cnt_q <= lin_cnt_d;
      out_val_q <= out_val_d;
      out_dat_q <= out_dat_d;
      out_pas_q <= out_pas_d;
      out_lst_q <= out_lst_d;
    end
  end

  // Line storage carries no reset; only committed slots are ever read.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_lin_q][wr_col_q] <= wr_dat_i;
  end

  assign rd_val_o = out_val_q;
  assign rd_dat_o = out_dat_q;
  assign rd_pas_o = out_pas_q;
  assign rd_lst_o = out_lst_q;
`ifdef LINE_FIFO_CNT_EN
  assign lvl_o = lin_cnt_q;
`endif

endmodule

// File: tb/tb_line_fifo.sv
// Self-checking bench for line_fifo: vector table, directed corner sequences and
// randomized traffic against a line/replay queue model.
module tb_line_fifo;
  localparam int LN = 2;
  localparam int RT = 3;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [8:0] cfg_w;
  logic       start, wr_val, rd_val;
  logic [7:0] wr_dat;
  logic       wr_rdy, rd_rdy, rd_vld, rd_lst;
  logic [7:0] rd_dat;
  logic [1:0] rd_pas;
`ifdef LINE_FIFO_CNT_EN
  logic [1:0] lvl;
`endif

  always #5 clk = ~clk;

  line_fifo #(.SIZE(256), .DATA_WD(8), .LINE_NUM(LN), .RD_TIMES(RT)) dut (
    .clk(clk), .rstn(rstn), .cfg_w_i(cfg_w), .start_i(start),
    .wr_val_i(wr_val), .wr_dat_i(wr_dat), .wr_rdy_o(wr_rdy),
    .rd_val_i(rd_val), .rd_rdy_o(rd_rdy), .rd_val_o(rd_vld),
    .rd_dat_o(rd_dat), .rd_pas_o(rd_pas), .rd_lst_o(rd_lst)
`ifdef LINE_FIFO_CNT_EN
    , .lvl_o(lvl)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: partial line, stored lines as a flat word queue, replay position.
  logic [7:0] wbuf[$];
  logic [7:0] exp_q[$];
  int         n_lines, rd_idx, n_rd;
  logic       e_val, e_lst;
  logic [7:0] e_dat;
  int         e_pas;

  task automatic drive(input logic wv, input logic [7:0] wd, input logic rv, input logic st);
    wr_val = wv; wr_dat = wd; rd_val = rv; start = st;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic step();
    int  w;
    bit  wr_ok, rd_ok;
    w = int'(cfg_w);
    wr_ok = (n_lines != LN);
    rd_ok = (n_lines != 0);
    e_val = 1'b0;
    if (start) begin
      wbuf.delete(); exp_q.delete(); n_lines = 0; rd_idx = 0;
    end else begin
      if (rd_val && rd_ok) begin
        e_val = 1'b1;
        e_dat = exp_q[rd_idx % w];
        e_pas = rd_idx / w;
        e_lst = (rd_idx == w * RT - 1);
        rd_idx++;
        if (rd_idx == w * RT) begin
          repeat (w) void'(exp_q.pop_front());
          rd_idx = 0;
          n_lines--;
        end
      end
      if (wr_val && wr_ok) begin
        wbuf.push_back(wr_dat);
        if (wbuf.size() == w) begin
          foreach (wbuf[i]) exp_q.push_back(wbuf[i]);
          wbuf.delete();
          n_lines++;
        end
      end
    end
    tick();
    chk("wr_rdy", wr_rdy, n_lines != LN);
    chk("rd_rdy", rd_rdy, n_lines != 0);
    chk("rd_val", rd_vld, e_val);
    chk("rd_dat", rd_dat, e_dat);
    chk("rd_pas", rd_pas, e_pas);
    chk("rd_lst", rd_lst, e_lst);
`ifdef LINE_FIFO_CNT_EN
    chk("lvl", lvl, n_lines);
`endif
    if (rd_vld) n_rd++;
  endtask

  task automatic restart(input logic [8:0] w);
    drive(0, 8'h00, 0, 1);
    step();
    cfg_w = w;
    drive(0, 8'h00, 0, 0);
  endtask

  task automatic traffic(input int ncyc, input int wpct, input int rpct, input int spct);
    for (int c = 0; c < ncyc; c++) begin
      drive($urandom_range(99) < wpct, 8'($urandom), $urandom_range(99) < rpct,
            $urandom_range(999) < spct);
      step();
    end
  endtask

  typedef struct {
    logic       wv; logic [7:0] wd; logic rv;
    logic       x_wr_rdy, x_rd_rdy, x_val;
    logic [7:0] x_dat; logic [1:0] x_pas; logic x_lst;
  } vec_t;
  vec_t tbl[16];

  initial begin
    int   wcnt;
    logic [7:0] d;
    logic acc;

    for (int i = 0; i < 4; i++)
      tbl[i] = '{1'b1, 8'(i + 1), 1'b0, 1'b1, (i == 3), 1'b0, 8'h00, 2'd0, 1'b0};
    for (int k = 0; k < 12; k++)
      tbl[4 + k] = '{1'b0, 8'h00, 1'b1, 1'b1, (k != 11), 1'b1,
                     8'(k % 4 + 1), 2'(k / 4), (k == 11)};

    cfg_w = 9'd4;
    drive(0, 8'h00, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_rdy", wr_rdy, 1); chk("rst_rd_rdy", rd_rdy, 0);
    chk("rst_val", rd_vld, 0);    chk("rst_dat", rd_dat, 0);
    chk("rst_pas", rd_pas, 0);    chk("rst_lst", rd_lst, 0);
    rstn = 1'b1;

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].wv, tbl[i].wd, tbl[i].rv, 0);
      tick();
      chk($sformatf("v%0d_wr_rdy", i), wr_rdy, tbl[i].x_wr_rdy);
      chk($sformatf("v%0d_rd_rdy", i), rd_rdy, tbl[i].x_rd_rdy);
      chk($sformatf("v%0d_val", i), rd_vld, tbl[i].x_val);
      chk($sformatf("v%0d_dat", i), rd_dat, tbl[i].x_dat);
      chk($sformatf("v%0d_pas", i), rd_pas, tbl[i].x_pas);
      chk($sformatf("v%0d_lst", i), rd_lst, tbl[i].x_lst);
    end
    n_lines = 0; rd_idx = 0; e_dat = 8'd4; e_pas = 2; e_lst = 1'b1; e_val = 1'b0;

    // Back-to-back writes of three lines: the third stalls until line one is released.
    restart(9'd4);
    d = 8'd1; wcnt = 0;
    for (int c = 0; c < 10; c++) begin
      drive(1, d, 0, 0); acc = wr_rdy; step();
      if (acc) begin d++; wcnt++; end
    end
    chk("bp_wcnt_full", wcnt, 8);
    chk("bp_full", wr_rdy, 0);
    for (int c = 0; c < 12; c++) begin
      drive(1, d, 1, 0); acc = wr_rdy; step();
      if (acc) begin d++; wcnt++; end
    end
    chk("bp_wcnt_stall", wcnt, 8);
    chk("bp_rdy_after_release", wr_rdy, 1);
    drive(1, d, 1, 0); acc = wr_rdy; step();
    if (acc) begin d++; wcnt++; end
    chk("bp_wcnt_resume", wcnt, 9);
    for (int c = 0; c < 40; c++) begin
      drive(wcnt < 12, d, 1, 0); acc = wr_rdy & (wcnt < 12); step();
      if (acc) begin d++; wcnt++; end
    end

    // Continuous streaming of 8 lines of 5 words.
    restart(9'd5);
    n_rd = 0; wcnt = 0;
    for (int c = 0; c < 300; c++) begin
      drive(wcnt < 40, 8'($urandom), 1, 0); acc = wr_rdy & (wcnt < 40); step();
      if (acc) wcnt++;
    end
    chk("stream_reads", n_rd, 120);
    chk("stream_drained", rd_rdy, 0);

    // Restart mid-line while a replay is in pass 1.
    restart(9'd4);
    for (int c = 0; c < 6; c++) begin drive(1, 8'(8'h40 + c), 0, 0); step(); end
    for (int c = 0; c < 5; c++) begin drive(0, 8'h00, 1, 0); step(); end
    chk("mid_pas", rd_pas, 1);
    drive(1, 8'hAA, 1, 1); step();
    chk("st_wr_rdy", wr_rdy, 1);
    chk("st_rd_rdy", rd_rdy, 0);
    chk("st_val", rd_vld, 0);
    for (int c = 0; c < 4; c++) begin drive(1, 8'(8'h10 + c), 0, 0); step(); end
    drive(0, 8'h00, 1, 0); step();
    chk("st_first_dat", rd_dat, 8'h10);
    chk("st_first_pas", rd_pas, 0);
    for (int c = 0; c < 11; c++) begin drive(0, 8'h00, 1, 0); step(); end
    chk("st_last_lst", rd_lst, 1);

    // Single-word lines, then randomized traffic with occasional restarts.
    restart(9'd1);
    drive(1, 8'h5A, 0, 0); step();
    chk("w1_rd_rdy", rd_rdy, 1);
    traffic(200, 60, 60, 0);
    restart(9'd3);
    traffic(400, 50, 50, 8);
    restart(9'($urandom_range(2, 7)));
    traffic(400, 70, 40, 0);
    traffic(100, 0, 100, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
